// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds the fetch state encoding, NOP encoding and reset PC default.
package mips_pkg;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_HOLD  = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle.
// Fetch side is master, memory side is slave.
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [31:0]       rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall and flush.
// Flush wins over stall and loads a NOP bubble.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [31:0]       i_instr,
    input  logic [ADDR_W-1:0] i_pc4,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc4,
    output logic              o_valid
);

    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc4;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS F stage: PCF, imem handshake, skid buffer, IF/ID register.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_wait counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              PCSrcD,
    input  logic [ADDR_W-1:0] PCBranchD,
    fetch_stage_if.master     imem,
    output logic [31:0]       InstrD,
    output logic [ADDR_W-1:0] PCPlus4D,
    output logic              ValidD,
    output logic              FetchBusy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_wait
`endif
);

    fetch_state_t      r_state, w_nstate;
    logic [ADDR_W-1:0] r_pcf, w_npcf;
    logic [ADDR_W-1:0] r_req_addr, w_nreq;
    logic [31:0]       r_skid_instr;
    logic [ADDR_W-1:0] r_skid_pc4;

    logic              w_hold, w_redir;
    logic [ADDR_W-1:0] w_pc4;
    logic              w_skid_ld, w_skid_clr;
    logic              w_stall, w_flush;
    logic [31:0]       w_d_instr;
    logic [ADDR_W-1:0] w_d_pc4;

    assign w_hold  = StallF | StallD;
    assign w_redir = PCSrcD & ~StallD;
    assign w_pc4   = r_pcf + ADDR_W'(4);

    always_comb begin
        w_nstate   = r_state;
        w_npcf     = r_pcf;
        w_nreq     = r_req_addr;
        w_skid_ld  = 1'b0;
        w_skid_clr = 1'b0;
        w_stall    = 1'b1;
        w_flush    = 1'b0;
        w_d_instr  = imem.rdata;
        w_d_pc4    = w_pc4;
        case (r_state)
            FS_FETCH: begin
                if (w_redir) begin
                    w_npcf  = PCBranchD;
                    w_flush = 1'b1;
                    // keep the abandoned address stable until memory answers
                    if (!imem.ready) begin
                        w_nstate = FS_DRAIN;
                        w_nreq   = r_pcf;
                    end
                end else if (imem.ready) begin
                    if (w_hold) begin
                        w_skid_ld = 1'b1;
                        w_nstate  = FS_HOLD;
                    end else begin
                        w_stall = 1'b0;
                        w_npcf  = w_pc4;
                    end
                end else if (!w_hold) begin
                    w_flush = 1'b1;
                end
            end
            FS_HOLD: begin
                if (w_redir) begin
                    w_skid_clr = 1'b1;
                    w_flush    = 1'b1;
                    w_npcf     = PCBranchD;
                    w_nstate   = FS_FETCH;
                end else if (!w_hold) begin
                    w_stall    = 1'b0;
                    w_d_instr  = r_skid_instr;
                    w_d_pc4    = r_skid_pc4;
                    w_npcf     = r_skid_pc4 + ADDR_W'(4);
                    w_skid_clr = 1'b1;
                    w_nstate   = FS_FETCH;
                end
            end
            FS_DRAIN: begin
                w_flush = ~StallD;
                if (w_redir)    w_npcf   = PCBranchD;
                if (imem.ready) w_nstate = FS_FETCH;
            end
            default: w_nstate = FS_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FS_FETCH;
            r_pcf        <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc4   <= '0;
        end else begin
            r_state    <= w_nstate;
            r_pcf      <= w_npcf;
            r_req_addr <= w_nreq;
            if (w_skid_ld) begin
                r_skid_instr <= imem.rdata;
                r_skid_pc4   <= w_pc4;
            end else if (w_skid_clr) begin
                r_skid_instr <= NOP_INSTR;
                r_skid_pc4   <= '0;
            end
        end
    end

    assign imem.req  = ~rst & (r_state != FS_HOLD);
    assign imem.addr = (r_state == FS_DRAIN) ? r_req_addr : r_pcf;
    assign FetchBusy = (r_state == FS_DRAIN) |
                       ((r_state == FS_FETCH) & ~imem.ready);

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .i_stall (w_stall),
        .i_flush (w_flush),
        .i_instr (w_d_instr),
        .i_pc4   (w_d_pc4),
        .o_instr (InstrD),
        .o_pc4   (PCPlus4D),
        .o_valid (ValidD)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched, r_perf_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_wait    <= '0;
        end else begin
            if (!w_stall && !w_flush) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (FetchBusy)            r_perf_wait    <= r_perf_wait + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_wait    = r_perf_wait;
`endif

endmodule
